// File: rtl/sp1_ram2p.sv
// sp1_ram2p: simple dual-port RAM with byte-enable writes, registered reads and a built-in clear engine
module sp1_ram2p #(
  parameter int DW = 32,
  parameter int AW = 6,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wcs,
  input  logic [DW/8-1:0] wbe,
  input  logic [AW-1:0]   wadr,
  input  logic [DW-1:0]   din,
  input  logic            rcs,
  input  logic [AW-1:0]   radr,
  output logic [DW-1:0]   dout,
  input  logic            clr,
  output logic            busy,
  output logic            acc_err
);
  localparam int NB = DW / 8;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] wdat, rdat;
  logic idle_acc;
  always_comb begin
    state_n = state == CLEAR ? (&cnt ? IDLE : CLEAR) : (clr ? CLEAR : IDLE);
    cnt_n = state == CLEAR ? cnt + 1'b1 : '0;
  end
  assign busy = state == CLEAR;
  assign idle_acc = !busy && !clr && !rst;
  always_comb begin
    wdat = mem[wadr];
    for (int i = 0; i < NB; i++) wdat[8*i+:8] = wbe[i] ? din[8*i+:8] : wdat[8*i+:8];
  end
  assign rdat = BYPASS && wcs && wadr == radr ? wdat : mem[radr];
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      cnt     <= '0;
      dout    <= '0;
      acc_err <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      acc_err <= busy && (wcs || rcs);
      dout    <= !idle_acc ? '0 : rcs ? rdat : dout;
    end
  end
  always_ff @(posedge clk) begin
    if (busy && !rst) mem[cnt] <= '0;
    else if (idle_acc && wcs) mem[wadr] <= wdat;
  end
endmodule

// File: tb/tb_sp1_ram2p.sv
// tb_sp1_ram2p: randomized and directed check of sp1_ram2p (both BYPASS settings) against an array model
module tb_sp1_ram2p;
  logic clk = 1'b0, rst, wcs, rcs, clr;
  logic [3:0] wbe;
  logic [5:0] wadr, radr;
  logic [31:0] din, dout1, dout0;
  logic busy1, busy0, err1, err0;
  int passed = 0, total = 0;
  logic [31:0] ref_mem [64];
  int clr_left = 64;
  logic [31:0] e_d1 = 0, e_d0 = 0;
  logic e_err = 0;
  always #5 clk = ~clk;
  sp1_ram2p #(.DW(32), .AW(6), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .wcs(wcs), .wbe(wbe), .wadr(wadr), .din(din), .rcs(rcs),
    .radr(radr), .dout(dout1), .clr(clr), .busy(busy1), .acc_err(err1));
  sp1_ram2p #(.DW(32), .AW(6), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wcs(wcs), .wbe(wbe), .wadr(wadr), .din(din), .rcs(rcs),
    .radr(radr), .dout(dout0), .clr(clr), .busy(busy0), .acc_err(err0));
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask
  task automatic cyc();
    logic [31:0] old, m;
    @(posedge clk);
    if (rst) begin
      clr_left = 64; e_d1 = 0; e_d0 = 0; e_err = 0;
    end else if (clr_left > 0) begin
      ref_mem[64-clr_left] = 0;
      clr_left--;
      e_err = wcs | rcs; e_d1 = 0; e_d0 = 0;
    end else begin
      e_err = 0;
      if (clr) begin
        clr_left = 64; e_d1 = 0; e_d0 = 0;
      end else begin
        old = ref_mem[radr];
        m = ref_mem[wadr];
        for (int b = 0; b < 4; b++) if (wbe[b]) m[8*b+:8] = din[8*b+:8];
        if (rcs) begin
          e_d0 = old;
          e_d1 = (wcs && wadr == radr) ? m : old;
        end
        if (wcs) ref_mem[wadr] = m;
      end
    end
    #1;
    chk("busy1", busy1, clr_left > 0);
    chk("busy0", busy0, clr_left > 0);
    chk("dout1", dout1, e_d1);
    chk("dout0", dout0, e_d0);
    chk("err1", err1, e_err);
    chk("err0", err0, e_err);
  endtask
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    wcs = 1; wadr = a; din = d; wbe = be;
    cyc();
    wcs = 0;
  endtask
  task automatic rd(input logic [5:0] a);
    rcs = 1; radr = a;
    cyc();
    rcs = 0;
  endtask
  initial begin
    rst = 1; wcs = 0; rcs = 0; clr = 0; wbe = 0; wadr = 0; radr = 0; din = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 0;
    repeat (3) cyc();
    rst = 0;
    for (int e = 1; e <= 64; e++) begin
      rcs = (e == 10);
      cyc();
      if (e == 10) chk("early_err", err1, 1);
      if (e == 63) chk("busy_63", busy1, 1);
    end
    rcs = 0;
    chk("busy_fall", busy1, 0);
    rd(6'h3f);
    chk("rd_3f", dout1, 32'h0);
    wr(6'h05, 32'hdeadbeef, 4'hf);
    rd(6'h05);
    chk("rd_full", dout1, 32'hdeadbeef);
    cyc();
    chk("hold", dout1, 32'hdeadbeef);
    wr(6'h05, 32'h11223344, 4'h5);
    rd(6'h05);
    chk("be5", dout1, 32'hde22be44);
    wr(6'h05, 32'hffffffff, 4'h0);
    rd(6'h05);
    chk("be0", dout1, 32'hde22be44);
    wr(6'h07, 32'haaaaaaaa, 4'hf);
    wcs = 1; rcs = 1; wadr = 6'h07; radr = 6'h07; din = 32'h12345678; wbe = 4'h3;
    cyc();
    wcs = 0; rcs = 0;
    chk("col_byp1", dout1, 32'haaaa5678);
    chk("col_byp0", dout0, 32'haaaaaaaa);
    rd(6'h07);
    chk("col_after", dout0, 32'haaaa5678);
    for (int a = 0; a < 64; a++) wr(6'(a), 32'h100 + a, 4'hf);
    clr = 1; wcs = 1; wadr = 6'h01; din = 32'hcafef00d; wbe = 4'hf;
    cyc();
    clr = 0; wcs = 0;
    chk("clr_busy", busy1, 1);
    repeat (64) cyc();
    chk("clr_done", busy1, 0);
    for (int a = 0; a < 64; a++) begin
      rd(6'(a));
      chk("clr_rd", dout1, 32'h0);
    end
    clr = 1;
    cyc();
    clr = 0;
    repeat (29) cyc();
    rst = 1;
    cyc();
    rst = 0;
    chk("mid_rst_busy", busy1, 1);
    repeat (63) cyc();
    chk("mid_rst_63", busy1, 1);
    cyc();
    chk("mid_rst_done", busy1, 0);
    rd(6'h3f);
    chk("mid_rst_3f", dout1, 32'h0);
    for (int n = 0; n < 3000; n++) begin
      wcs = 1'($urandom);
      rcs = 1'($urandom);
      wadr = $urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      radr = $urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      din = $urandom;
      wbe = 4'($urandom);
      clr = ($urandom_range(0, 299) == 0);
      rst = ($urandom_range(0, 799) == 0);
      cyc();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
